sqrt_operand_sequencer: RTL
===========================

// Module: sqrt_operand_sequencer
// PURPOSE
//  Upstream feeder for the digit-by-digit square-root core. Buffers operands from
//  a valid/ready source in a small FIFO and presents one operand at a time to the
//  core. Pulses the core start, holds the operand stable for all iterations, then
//  captures the root with its operand into an output register behind valid/ready.
// PARAMETERS
//  NUM_W       6  operand width; must be even
//  ROOT_W      3  root width; must equal NUM_W/2
//  FIFO_DEPTH  4  operand FIFO entries; power of 2, >=2
//  (localparam ITERS = NUM_W/2 core iterations, one per clock)
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-low reset (0 = reset)
//  in_num     in   NUM_W        operand from source
//  in_valid   in   1            in_num valid
//  in_ready   out  1            FIFO can accept; push when in_valid&&in_ready
//  sq_num     out  NUM_W        operand driven to core, registered
//  sq_start   out  1            one-cycle pulse; core clears root/remainder/index
//  sq_root    in   ROOT_W       core root output
//  out_num    out  NUM_W        operand belonging to out_root
//  out_root   out  ROOT_W       captured root
//  out_valid  out  1            out_num/out_root valid
//  out_ready  in   1            consumer accepts when out_valid&&out_ready
//  fifo_count out  clog2(D)+1   FIFO occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (reset=0, async): FIFO emptied, fifo_count=0, state=IDLE, in_ready=0 while
//   asserted, then 1; sq_num=0, sq_start=0, out_num=0, out_root=0, out_valid=0.
//  FIFO: in_ready = (fifo_count != FIFO_DEPTH); registered, no input bypass.
//   Push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo
//   FIFO_DEPTH. An operand pushed at edge t is poppable at edge t+1 at the earliest.
//  FSM states and transitions, one per edge:
//   IDLE : fifo_count!=0 -> pop head into sq_num; go START; else stay
//   START: sq_start=1 this cycle only; iter_cnt<=ITERS; go RUN
//   RUN  : iter_cnt decrements each edge; at iter_cnt==1, go CAPT
//   CAPT : out_root<=sq_root, out_num<=sq_num, out_valid<=1; go HOLD
//   HOLD : out_valid&&out_ready -> out_valid<=0; go IDLE
//  Latency: leave IDLE at edge E; sq_start high during cycle E..E+1; out_valid
//   rises at edge E+ITERS+2 (E+5 for NUM_W=6). Best-case throughput is one operand
//   per ITERS+4 cycles with out_ready held at 1.
//  sq_num is stable from leaving IDLE until the next pop. It never changes while
//   the FSM is in START, RUN or CAPT.
//  out_num/out_root stay stable while out_valid=1 and out_ready=0.
//  The FIFO keeps accepting operands in every state, including HOLD.
//  Widths: sq_root is taken as ROOT_W unsigned. No arithmetic on the datapath.
//  Reset mid-operation (any state): the in-flight operand and all queued operands
//   are discarded, no partial out_valid is produced, and sq_start stays 0.
//  sq_start is asserted only in START and is never asserted during reset.
// TESTING
//  Push 36, out_ready=1, core model attached -> out_valid 5 edges after leaving
//   IDLE; out_root=6, out_num=36, sq_start high exactly one cycle.
//  Push 63, then 0, then 1 back-to-back -> results in order: (63,7), (0,0), (1,1);
//   sq_num constant throughout each START..CAPT window.
//  out_ready=0, push 6 operands back-to-back -> 1st popped to core, next 4 fill
//   FIFO (fifo_count=4); in_ready=0 on the 6th until a pop. out_root stays stable
//   across 10 stalled cycles.
//  Simultaneous push and pop in IDLE with fifo_count=2 -> fifo_count stays 2;
//   pointer wrap verified after 9 push/pop pairs.
//  Assert reset=0 during RUN with 3 operands queued -> every output at its reset
//   value immediately (async); after release, fifo_count=0, no stale out_valid;
//   a new push of 49 -> out_root=7.

Source files
------------

// File: rtl/sqrt_operand_sequencer_if.sv
// Operand, core and result handshake bundle for the square-root operand sequencer.
// slave = sequencer side, master = source/core/consumer side.
interface sqrt_operand_sequencer_if #(
  parameter int NUM_W      = 6,
  parameter int ROOT_W     = 3,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_W-1:0]  in_num;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_W-1:0]  sq_num;
  logic              sq_start;
  logic [ROOT_W-1:0] sq_root;
  logic [NUM_W-1:0]  out_num;
  logic [ROOT_W-1:0] out_root;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  in_num, in_valid, sq_root, out_ready,
    output in_ready, sq_num, sq_start, out_num, out_root, out_valid, fifo_count
  );

  modport master (
    output in_num, in_valid, sq_root, out_ready,
    input  in_ready, sq_num, sq_start, out_num, out_root, out_valid, fifo_count
  );
endinterface

// File: rtl/sqrt_operand_sequencer.sv
// FIFO-buffered feeder for the iterative sqrt core; result valid ITERS+2 edges after a pop.
// Input stalls only on a full FIFO; the result register holds until out_ready.
module sqrt_operand_sequencer #(
  parameter int NUM_W      = 6,
  parameter int ROOT_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  sqrt_operand_sequencer_if.slave bus
);
  localparam int ITERS  = NUM_W / 2;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int ITER_W = $clog2(ITERS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_CAPT,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [NUM_W-1:0]  num;
    logic [ROOT_W-1:0] root;
  } res_t;

  logic [NUM_W-1:0]  mem_q [FIFO_DEPTH];
  logic [NUM_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [NUM_W-1:0]  sq_num_q, sq_num_d;
  logic              sq_start_q, sq_start_d;
  res_t              res_q, res_d;
  logic              out_valid_q, out_valid_d;

  logic push;
  logic pop;

  always_comb begin
    push        = bus.in_valid && in_ready_q;
    pop         = (state_q == S_IDLE) && (cnt_q != '0);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    iter_d      = iter_q;
    sq_num_d    = sq_num_q;
    sq_start_d  = 1'b0;
    res_d       = res_q;
    out_valid_d = out_valid_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.in_num;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // Registered from the next count, so a full FIFO blocks the very next edge.
    in_ready_d = (cnt_d != CNT_W'(FIFO_DEPTH));

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sq_num_d   = mem_q[rd_ptr_q];
          sq_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        iter_d  = ITER_W'(ITERS);
        state_d = S_RUN;
      end
      S_RUN: begin
        iter_d = iter_q - ITER_W'(1);
        if (iter_q == ITER_W'(1)) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        res_d.root  = bus.sq_root;
        res_d.num   = sq_num_q;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      state_q     <= S_IDLE;
      iter_q      <= '0;
      sq_num_q    <= '0;
      sq_start_q  <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      state_q     <= state_d;
      iter_q      <= iter_d;
      sq_num_q    <= sq_num_d;
      sq_start_q  <= sq_start_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.sq_num     = sq_num_q;
  assign bus.sq_start   = sq_start_q;
  assign bus.out_num    = res_q.num;
  assign bus.out_root   = res_q.root;
  assign bus.out_valid  = out_valid_q;
  assign bus.fifo_count = cnt_q;
endmodule
